// File: rtl/hex_display_scanner.sv
// Time-multiplexed driver for an N-digit 7-segment display bank.
// A snapshot of the hex word is scanned one digit per refresh period,
// with leading-zero blanking, per-digit decimal points, a global enable
// and selectable segment/anode polarity. All pins are registered.
module hex_display_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] inp_value,
  input  logic                    inp_load,
  input  logic [NUM_DIGITS-1:0]   inp_dp,
  input  logic                    inp_blank_lz,
  input  logic                    inp_enable,
  output logic [6:0]              out_seg,
  output logic                    out_dp,
  output logic [NUM_DIGITS-1:0]   out_anode,
  output logic [IDX_W-1:0]        out_digit_idx
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(NUM_DIGITS - 1);
  // Inactive levels; XOR with these converts an active-high pattern to pin polarity
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  // Standard hex-to-segment encoding, active-low form, bits g..a
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h27;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    tick;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [IDX_W-1:0]        oidx_q, oidx_d;

  logic [3:0]              nib;
  logic                    dp_req;
  logic                    upper_zero;
  logic                    blank;

  // Snapshot capture, refresh divider and digit index advance
  always_comb begin
    snap_d = inp_load ? inp_value : snap_q;
    dps_d  = inp_load ? inp_dp : dps_q;
    tick   = inp_enable && (cnt_q == CNT_MAX);
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    if (inp_enable) begin
      if (tick) begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Select the active digit and decide blanking; scanning from the top
  // accumulates "this digit and all above are zero"
  always_comb begin
    nib        = 4'h0;
    dp_req     = 1'b0;
    upper_zero = 1'b1;
    blank      = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (snap_q[4*i +: 4] == 4'h0);
      if (IDX_W'(i) == idx_q) begin
        nib    = snap_q[4*i +: 4];
        dp_req = dps_q[i];
        blank  = inp_blank_lz && (i != 0) && upper_zero;
      end
    end
  end

  // Next pin values; a disabled display goes fully dark but keeps its index
  always_comb begin
    seg_d  = SEG_OFF;
    dp_d   = DP_OFF;
    an_d   = AN_OFF;
    oidx_d = idx_q;
    if (inp_enable) begin
      seg_d = blank ? SEG_OFF : (hex_to_seg(nib) ^ {7{~SEG_ACTIVE_LOW}});
      dp_d  = dp_req ? ~DP_OFF : DP_OFF;
      an_d  = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_q <= '0;
      dps_q  <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      seg_q  <= SEG_OFF;
      dp_q   <= DP_OFF;
      an_q   <= AN_OFF;
      oidx_q <= '0;
    end else begin
      snap_q <= snap_d;
      dps_q  <= dps_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      an_q   <= an_d;
      oidx_q <= oidx_d;
    end
  end

  assign out_seg       = seg_q;
  assign out_dp        = dp_q;
  assign out_anode     = an_q;
  assign out_digit_idx = oidx_q;

endmodule
